// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Optional MADD/MSUB (ops 6/7) accumulate into {hi,lo} when MDU_MADD_EN is defined.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  counter;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_vld;

  function automatic logic signed [63:0] mul_signed(input logic signed [31:0] a,
                                                    input logic signed [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = a;
    eb = b;
    return ea * eb;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Sign-magnitude divide: avoids the 0x80000000 / -1 overflow and gives a
  // remainder with the dividend's sign. Returns {remainder, quotient}.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? 32'(-a) : 32'(a);
    mag_b = b[31] ? 32'(-b) : 32'(b);
    if (mag_b == 32'd0) mag_b = 32'd1;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    return {a % d, a / d};
  endfunction

  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        quot_s;
  logic [63:0]        quot_u;
  logic               div_zero;

  assign a_s      = src_a;
  assign b_s      = src_b;
  assign prod_s   = mul_signed(a_s, b_s);
  assign prod_u   = mul_unsigned(src_a, src_b);
  assign quot_s   = div_signed(a_s, b_s);
  assign quot_u   = div_unsigned(src_a, src_b);
  assign div_zero = (src_b == 32'd0);

`ifdef MDU_MADD_EN
  logic [63:0] acc_add;
  logic [63:0] acc_sub;
  assign acc_add = {hi, lo} + 64'(prod_s);
  assign acc_sub = {hi, lo} - 64'(prod_s);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      counter <= 4'd0;
      res_vld <= 1'b0;
      res_hi  <= 32'd0;
      res_lo  <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {res_hi, res_lo} <= prod_s;
                res_vld <= 1'b1;
                counter <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MULTU: begin
                {res_hi, res_lo} <= prod_u;
                res_vld <= 1'b1;
                counter <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIV: begin
                {res_hi, res_lo} <= quot_s;
                res_vld <= !div_zero;
                counter <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_DIVU: begin
                {res_hi, res_lo} <= quot_u;
                res_vld <= !div_zero;
                counter <= DIV_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
`ifdef MDU_MADD_EN
              OP_MADD: begin
                {res_hi, res_lo} <= acc_add;
                res_vld <= 1'b1;
                counter <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
              OP_MSUB: begin
                {res_hi, res_lo} <= acc_sub;
                res_vld <= 1'b1;
                counter <= MULT_LOAD;
                busy    <= 1'b1;
                state   <= RUN;
              end
`endif
              default: ;
            endcase
          end
        end
        RUN: begin
          // Completion edge: commit the captured result unless it was a divide by zero.
          if (counter == 4'd0) begin
            if (res_vld) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            res_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed scoreboard bench for mdu_unit: busy length, hi/lo results and
// the ignore/divide-by-zero/reset boundary cases.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          checks   = 0;
  int          failures = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns #1 after the start edge.
  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h0BAD_F00D;
  endtask

  // Count busy cycles (pre already elapsed), require hi/lo to hold the model
  // values until completion, then compare against the scoreboard head.
  task automatic wait_done(input string tag, input int n, input int pre);
    int   cnt;
    logic stable;
    exp_t e;
    cnt    = pre;
    stable = 1'b1;
    while (busy === 1'b1 && cnt < 40) begin
      if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
      cnt++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    check({tag, "_hold"}, {31'd0, stable}, 32'd1);
    e = sb.pop_front();
    check({tag, "_hi"}, hi, e.h);
    check({tag, "_lo"}, lo, e.l);
    m_hi = e.h;
    m_lo = e.l;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    sb.push_back('{h: eh, l: el});
    pulse(o, a, b);
    wait_done(tag, n, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;

    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
    run_op("div_negdivisor", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    // Starts while busy must be ignored entirely.
    sb.push_back('{h: 32'h0000_0001, l: 32'h0000_0000});
    pulse(3'd1, 32'h0001_0000, 32'h0001_0000);
    pulse(3'd5, 32'h0000_1234, 32'd0);
    pulse(3'd0, 32'h0000_0003, 32'h0000_0003);
    wait_done("busy_ignore", 5, 2);
    tick();
    check("busy_ignore_after_busy", {31'd0, busy}, 32'd0);
    check("busy_ignore_after_lo", lo, 32'd0);

`ifndef MDU_MADD_EN
    pulse(3'd6, 32'h1111_1111, 32'h2222_2222);
    check("reserved_busy", {31'd0, busy}, 32'd0);
    check("reserved_hi", hi, m_hi);
    check("reserved_lo", lo, m_lo);
`endif

    pulse(3'd4, 32'hAAAA_0000, 32'd0);
    check("mthi_hi", hi, 32'hAAAA_0000);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    pulse(3'd5, 32'h0000_5555, 32'd0);
    check("mtlo_lo", lo, 32'h0000_5555);
    check("mtlo_hi", hi, 32'hAAAA_0000);
    m_hi = 32'hAAAA_0000;
    m_lo = 32'h0000_5555;

    run_op("div_zero", 3'd2, 32'd100, 32'd0, 10, 32'hAAAA_0000, 32'h0000_5555);
    run_op("divu_zero", 3'd3, 32'd100, 32'd0, 10, 32'hAAAA_0000, 32'h0000_5555);

    // Reset in the middle of a divide discards the pending result.
    pulse(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("midrst_late_busy", {31'd0, busy}, 32'd0);
    check("midrst_late_hi", hi, 32'd0);
    check("midrst_late_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;

    run_op("div_after_rst", 3'd2, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits beside the ALU and consumes the two GRF read operands (rs data, rt data). Its HI/LO results feed the register write-back mux for mfhi/mflo.
- Exposes `busy` so the controller can stall any dependent HI/LO access.

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
- start  input  1  launch request; sampled each rising edge.
- op  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (see Optional Feature).
- src_a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- src_b  input  32  rt operand (divisor / multiplier).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset==0 at a clk edge): hi=0, lo=0, busy=0, counter=0, pending result cleared.
  - Reset overrides everything, including an operation already in flight; that result is discarded.
- State machine:
  - IDLE: busy=0. When start=1 and op=MULT/MULTU/DIV/DIVU, at that edge: compute the full result into internal regs res_hi/res_lo, load counter with N-1 (N = MULT_CYCLES or DIV_CYCLES), set busy=1, go to RUN.
  - RUN: counter decrements each edge. At the edge where counter==0: hi<=res_hi, lo<=res_lo, busy<=0, go to IDLE.
  - Net timing: with start sampled at edge E, busy is high for exactly N cycles and hi/lo update at edge E+N.
- start while busy=1 is ignored entirely: no queueing, no effect on the running op or hi/lo.
- MTHI/MTLO, when busy=0 and start=1: hi (or lo) <= src_a at that same edge. busy stays 0 (1-cycle latency). While busy=1 they are ignored.
- Reserved op (6/7), with Optional Feature disabled: ignored, no state change.
- MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
- MULTU: the same, unsigned.
- DIV: signed. lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (src_b==0, DIV or DIVU): the op still takes DIV_CYCLES with busy high, but hi and lo keep their prior values at completion.
- Operands are captured at the start edge. src_a/src_b changes during RUN have no effect.
- hi/lo are never modified mid-operation. They hold their old values until the completion edge.
- The completion edge and a new start edge cannot coincide, because busy=1 on that edge. A start one cycle after completion is accepted normally.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: op 6 = MADD and op 7 = MSUB, both signed, accumulating into the 64-bit {hi,lo}.
  - The 64-bit accumulate uses {hi,lo} as of the start edge and wraps modulo 2^64.
  - Latency MULT_CYCLES; the same busy and ignore rules as MULT.
- Undefined: ops 6/7 are ignored as reserved. No accumulator logic is synthesized.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, release, no start -> hi=0, lo=0, busy=0.
2. MULT timing: src_a=0xFFFFFFFE (-2), src_b=3, op=0, start pulse at edge E -> busy=1 for exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA at E+5; no change before E+5.
3. DIV signed: src_a=-7 (0xFFFFFFF9), src_b=2, op=2 -> at E+10, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with op=3 (DIVU) and 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1.
4. Ignore while busy: during a MULTU of 0x10000 by 0x10000, pulse MTLO with src_a=0x1234 and a second MULT -> final hi=1, lo=0, and busy drops after 5 cycles with no extension.
5. Divide by zero: first MTHI 0xAAAA0000, then MTLO 0x5555 -> hi/lo update on the next edge. Then DIV by 0 -> busy high 10 cycles; hi=0xAAAA0000, lo=0x5555 unchanged.
6. Reset mid-operation: start DIV 100/7, assert reset=0 at cycle 4 -> busy=0, hi=lo=0 next edge; no late write after reset is released.
